// File: rtl/data_mem_ctrl.sv
// Byte-addressed data memory for the CPU memory stage.
// One load or store per cycle over a valid/ready port, registered response,
// sub-word stores with lane masking, sign/zero-extended loads, access error
// detection and an optional post-reset clear sweep of the array.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_RESET | held in reset (sweep disabled); leaves to S_RUN on 1st edge
//   S_INIT  | clearing word 'sweep' this cycle; requests not accepted
//   S_RUN   | accepting one request per cycle until the next reset
module data_mem_ctrl #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 64,
  parameter int ADDR_W    = 32,
  parameter int INIT_ZERO = 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_busy
);

  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_RESET, S_INIT, S_RUN} state_t;

  // With the sweep enabled the reset state is already the first sweep cycle,
  // so word 0 is cleared on the first edge after release.
  localparam state_t S_START = (INIT_ZERO != 0) ? S_INIT : S_RESET;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state, state_nx;
  logic [IW-1:0]     sweep, sweep_nx;
  logic              init_we;

  logic              accept;
  logic [LB-1:0]     off;
  logic [IW-1:0]     idx;
  logic [LB+2:0]     bit_off;
  logic [31:0]       size_bits;
  logic [LB-1:0]     align_mask;
  logic              err_size, err_align, err_range, err;
  logic [NB-1:0]     val_lane;
  logic [DATA_W-1:0] val_mask;
  logic [DATA_W-1:0] wr_mask, wr_data;
  logic [DATA_W-1:0] old_word, shifted, load_data;
  logic              sign_bit;

  logic              mem_we;
  logic [IW-1:0]     mem_idx;
  logic [DATA_W-1:0] mem_wd;

  // State and sweep counter registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= S_START;
      sweep <= '0;
    end else begin
      state <= state_nx;
      sweep <= sweep_nx;
    end
  end

  // Next-state logic; the counter parks at DEPTH-1 when the sweep ends.
  always_comb begin
    state_nx = state;
    sweep_nx = sweep;
    init_we  = 1'b0;
    case (state)
      S_RESET: state_nx = (INIT_ZERO != 0) ? S_INIT : S_RUN;
      S_INIT: begin
        init_we = 1'b1;
        if (sweep == IW'(DEPTH - 1)) state_nx = S_RUN;
        else                         sweep_nx = sweep + 1'b1;
      end
      S_RUN:   state_nx = S_RUN;
      default: state_nx = S_START;
    endcase
  end

  assign req_ready = (state == S_RUN);
  assign init_busy = (state == S_INIT);
  assign accept    = req_valid && req_ready;

  // Address decode, error checks, lane masks, store merge and load extract.
  always_comb begin
    off        = req_addr[LB-1:0];
    idx        = req_addr[LB+IW-1:LB];
    bit_off    = {off, 3'b000};
    size_bits  = 32'd8 << req_size;
    align_mask = LB'((32'd1 << req_size) - 32'd1);
    err_size   = size_bits > 32'(DATA_W);
    err_align  = (off & align_mask) != '0;
    err_range  = (req_addr >> (LB + IW)) != '0;
    err        = err_size || err_align || err_range;

    val_lane = '0;
    val_mask = '0;
    for (int i = 0; i < NB; i++) begin
      val_lane[i]        = 32'(i) < (32'd1 << req_size);
      val_mask[8*i +: 8] = {8{val_lane[i]}};
    end

    old_word = mem[idx];
    wr_mask  = val_mask << bit_off;
    wr_data  = (req_wdata & val_mask) << bit_off;

    shifted = old_word >> bit_off;
    case (req_size)
      2'd0:    sign_bit = shifted[7];
      2'd1:    sign_bit = shifted[15];
      2'd2:    sign_bit = shifted[31];
      default: sign_bit = shifted[DATA_W-1];
    endcase
    // A full-width load has val_mask all ones, so the fill term vanishes.
    load_data = (shifted & val_mask) |
                ((!req_unsigned && sign_bit) ? ~val_mask : '0);
  end

  // Single write port shared by the clear sweep and accepted stores.
  always_comb begin
    mem_we  = init_we || (accept && req_we && !err);
    mem_idx = init_we ? sweep : idx;
    mem_wd  = init_we ? '0 : ((old_word & ~wr_mask) | wr_data);
  end

  // Storage array; intentionally has no reset.
  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_idx] <= mem_wd;
  end

  // Response registers: valid for the cycle after acceptance.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= accept;
      rsp_err   <= accept && err;
      rsp_rdata <= (accept && !err && !req_we) ? load_data : '0;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: a 32-bit instance with the clear sweep
// and a 64-bit instance without it, sharing clock and reset.
module tb_data_mem_ctrl;

  logic        clock;
  logic        resetn;

  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err, init_busy;
  logic [31:0] rsp_rdata;

  logic        req_valid64, req_ready64, req_we64, req_unsigned64;
  logic [1:0]  req_size64;
  logic [31:0] req_addr64;
  logic [63:0] req_wdata64;
  logic        rsp_valid64, rsp_err64, init_busy64;
  logic [63:0] rsp_rdata64;

  int tests = 0;
  int fails = 0;
  int cycles;

  data_mem_ctrl #(.DATA_W(32), .DEPTH(64), .ADDR_W(32), .INIT_ZERO(1)) u_dut (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata), .init_busy(init_busy)
  );

  data_mem_ctrl #(.DATA_W(64), .DEPTH(64), .ADDR_W(32), .INIT_ZERO(0)) u_dut64 (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid64), .req_ready(req_ready64), .req_we(req_we64),
    .req_size(req_size64), .req_unsigned(req_unsigned64), .req_addr(req_addr64),
    .req_wdata(req_wdata64), .rsp_valid(rsp_valid64), .rsp_err(rsp_err64),
    .rsp_rdata(rsp_rdata64), .init_busy(init_busy64)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request, let it be taken at the next edge, sample #1 later.
  task automatic req(input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic req64(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [63:0] wdata);
    req_valid64 = 1'b1; req_we64 = we; req_size64 = size; req_unsigned64 = uns;
    req_addr64 = addr; req_wdata64 = wdata;
    @(posedge clock); #1;
    req_valid64 = 1'b0;
  endtask

  // Counts edges from release until req_ready rises, bounded at 200.
  task automatic wait_ready(output int n);
    n = 0;
    while (!req_ready && n < 200) begin
      @(posedge clock); #1;
      n++;
      if (n == 1) check("ready64_first_edge", {63'd0, req_ready64}, 64'd1);
    end
  endtask

  initial begin
    req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
    req_valid64 = 0; req_we64 = 0; req_size64 = 0; req_unsigned64 = 0;
    req_addr64 = 0; req_wdata64 = 0;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #2;
    check("rst_ready",     {63'd0, req_ready}, 64'd0);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_rsp_err",   {63'd0, rsp_err},   64'd0);
    check("rst_rdata",     {32'd0, rsp_rdata}, 64'd0);
    check("rst_init_busy", {63'd0, init_busy}, 64'd1);
    check("rst_busy64",    {63'd0, init_busy64}, 64'd0);
    check("rst_ready64",   {63'd0, req_ready64}, 64'd0);

    repeat (2) @(posedge clock);
    @(negedge clock) resetn = 1'b1;
    wait_ready(cycles);
    check("sweep_cycles", 64'(cycles), 64'd64);
    check("busy_after_sweep", {63'd0, init_busy}, 64'd0);

    for (int a = 0; a < 64; a++) begin
      req(1'b0, 2'd2, 1'b0, 32'(a * 4), 32'd0);
      check("sweep_valid", {63'd0, rsp_valid}, 64'd1);
      check("sweep_zero", {31'd0, rsp_err, rsp_rdata}, 64'd0);
    end

    // Sub-word stores; upper store-data bits must be ignored.
    req(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344);
    check("sw_valid", {63'd0, rsp_valid}, 64'd1);
    check("sw_rsp", {31'd0, rsp_err, rsp_rdata}, 64'd0);
    req(1'b1, 2'd0, 1'b0, 32'h11, 32'h123456AA);
    req(1'b1, 2'd1, 1'b0, 32'h12, 32'h7777BEEF);
    req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
    check("lw_merged", {32'd0, rsp_rdata}, 64'hBEEFAA44);
    req(1'b0, 2'd0, 1'b0, 32'h11, 32'd0);
    check("lb_signed", {32'd0, rsp_rdata}, 64'hFFFFFFAA);
    req(1'b0, 2'd0, 1'b1, 32'h11, 32'd0);
    check("lbu", {32'd0, rsp_rdata}, 64'h000000AA);
    req(1'b0, 2'd1, 1'b0, 32'h12, 32'd0);
    check("lh_signed", {32'd0, rsp_rdata}, 64'hFFFFBEEF);
    req(1'b0, 2'd1, 1'b1, 32'h12, 32'd0);
    check("lhu", {32'd0, rsp_rdata}, 64'h0000BEEF);
    req(1'b0, 2'd0, 1'b0, 32'h10, 32'd0);
    check("lb_pos", {32'd0, rsp_rdata}, 64'h00000044);

    // Errors.
    req(1'b0, 2'd1, 1'b0, 32'h13, 32'd0);
    check("misalign_err", {63'd0, rsp_err}, 64'd1);
    check("misalign_rdata", {32'd0, rsp_rdata}, 64'd0);
    req(1'b1, 2'd2, 1'b0, 32'h12, 32'h99999999);
    check("misalign_st_err", {63'd0, rsp_err}, 64'd1);
    req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
    check("misalign_st_nowrite", {32'd0, rsp_rdata}, 64'hBEEFAA44);
    req(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF);
    check("range_err", {63'd0, rsp_err}, 64'd1);
    req(1'b0, 2'd2, 1'b0, 32'h0, 32'd0);
    check("range_nowrite", {31'd0, rsp_err, rsp_rdata}, 64'd0);
    req(1'b0, 2'd3, 1'b0, 32'h10, 32'd0);
    check("size_err", {63'd0, rsp_err}, 64'd1);
    check("size_rdata", {32'd0, rsp_rdata}, 64'd0);
    req(1'b1, 2'd3, 1'b0, 32'h18, 32'h55555555);
    check("size_st_err", {63'd0, rsp_err}, 64'd1);
    req(1'b0, 2'd2, 1'b0, 32'h18, 32'd0);
    check("size_st_nowrite", {31'd0, rsp_err, rsp_rdata}, 64'd0);

    // Back-to-back store then load of the same word.
    req(1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFEF00D);
    check("raw_st_valid", {63'd0, rsp_valid}, 64'd1);
    req(1'b0, 2'd2, 1'b0, 32'h20, 32'd0);
    check("raw_ld_valid", {63'd0, rsp_valid}, 64'd1);
    check("raw_ld_data", {31'd0, rsp_err, rsp_rdata}, 64'h00000000CAFEF00D);

    // 64-bit instance.
    req64(1'b1, 2'd3, 1'b0, 32'h08, 64'h0123456789ABCDEF);
    check("d64_st", {rsp_err64, rsp_valid64}, 64'd1);
    req64(1'b0, 2'd2, 1'b0, 32'h0C, 64'd0);
    check("d64_lw_hi", rsp_rdata64, 64'h0000000001234567);
    req64(1'b0, 2'd2, 1'b0, 32'h08, 64'd0);
    check("d64_lw_lo_signed", rsp_rdata64, 64'hFFFFFFFF89ABCDEF);
    req64(1'b0, 2'd3, 1'b1, 32'h08, 64'd0);
    check("d64_ld", rsp_rdata64, 64'h0123456789ABCDEF);

    // Reset while a response is being presented.
    req(1'b0, 2'd2, 1'b0, 32'h20, 32'd0);
    check("pre_rst_data", {32'd0, rsp_rdata}, 64'h00000000CAFEF00D);
    #1 resetn = 1'b0;
    #1;
    check("mid_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("mid_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
    check("mid_rsp_ready", {63'd0, req_ready}, 64'd0);
    check("mid_rsp_busy",  {63'd0, init_busy}, 64'd1);
    repeat (2) @(posedge clock);
    @(negedge clock) resetn = 1'b1;

    // Reset at sweep cycle 30, held for two cycles.
    repeat (30) @(posedge clock);
    #1;
    check("mid_sweep_busy", {63'd0, init_busy}, 64'd1);
    resetn = 1'b0;
    #1;
    check("mid_sweep_ready", {63'd0, req_ready}, 64'd0);
    check("mid_sweep_rsp", {31'd0, rsp_valid, rsp_err}, 64'd0);
    repeat (2) @(posedge clock);
    @(negedge clock) resetn = 1'b1;
    wait_ready(cycles);
    check("resweep_cycles", 64'(cycles), 64'd64);
    req(1'b0, 2'd2, 1'b0, 32'h20, 32'd0);
    check("resweep_clear20", {31'd0, rsp_err, rsp_rdata}, 64'd0);
    req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
    check("resweep_clear10", {31'd0, rsp_err, rsp_rdata}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
